// File: rtl/qam_tx_pkg.sv
// ============================================================================
// qam_tx_pkg : shared mode encodings, FSM states and Gray level helper
// Rev 1.0
// ============================================================================
`default_nettype none

package qam_tx_pkg;

    localparam logic MODE_QPSK  = 1'b0;
    localparam logic MODE_16QAM = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Gray-coded 2-bit group to a signed amplitude level in units of AMP
    function automatic logic signed [2:0] gray2lvl(input logic [1:0] g);
        case (g)
            2'b00:   gray2lvl = -3'sd3;
            2'b01:   gray2lvl = -3'sd1;
            2'b11:   gray2lvl = 3'sd1;
            default: gray2lvl = 3'sd3;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/qam_tx_frontend_if.sv
// ============================================================================
// qam_tx_frontend_if : source-bit and I/Q-symbol handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface qam_tx_frontend_if #(
    parameter int W = 9
);
    logic                mode;
    logic                in_valid;
    logic                in_ready;
    logic                in_bit;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_i;
    logic signed [W-1:0] out_q;
    logic                out_last;

    modport master (
        output mode, in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_i, out_q, out_last
    );

    modport slave (
        input  mode, in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_i, out_q, out_last
    );
endinterface

`default_nettype wire

// File: rtl/conv_enc_k.sv
// ============================================================================
// conv_enc_k : rate-1/2 feed-forward convolutional encoder, zero-force tail
// Rev 1.0
// ============================================================================
`default_nettype none

module conv_enc_k #(
    parameter int           K  = 3,
    parameter logic [K-1:0] G0 = 3'b111,
    parameter logic [K-1:0] G1 = 3'b101
) (
    input  wire  clk,
    input  wire  reset,
    input  wire  en_i,
    input  wire  zero_i,
    input  wire  bit_i,
    output logic c0_o,
    output logic c1_o
);

    logic [K-2:0] sr_q, sr_d;
    logic         u;
    logic [K-1:0] taps;

    always_comb begin
        u    = bit_i & ~zero_i;
        taps = {u, sr_q};
        c0_o = ^(G0 & taps);
        c1_o = ^(G1 & taps);
        sr_d = en_i ? {u, sr_q[K-2:1]} : sr_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/qam_tx_frontend.sv
// ============================================================================
// qam_tx_frontend : conv encoder + QPSK/16-QAM Gray mapper with tail flush
// Rev 1.0
// ============================================================================
`default_nettype none

module qam_tx_frontend
    import qam_tx_pkg::*;
#(
    parameter int           K   = 3,
    parameter logic [K-1:0] G0  = 3'b111,
    parameter logic [K-1:0] G1  = 3'b101,
    parameter int           W   = 9,
    parameter int           AMP = 32
) (
    input wire clk,
    input wire reset,
    qam_tx_frontend_if.slave bus
);

    localparam int                  c_TW        = $clog2(K);
    localparam logic [c_TW-1:0]     c_TAIL_LAST = c_TW'(K - 2);
    localparam logic signed [W-1:0] c_AMP       = W'(AMP);

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic                half_q, half_d;
    logic [1:0]          acc_q, acc_d;
    logic [c_TW-1:0]     tail_q, tail_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic signed [W-1:0] i_smp_q, i_smp_d;
    logic signed [W-1:0] q_smp_q, q_smp_d;

    logic                slot, in_ready, in_fire, flush_step, tail_last;
    logic                enc_en, enc_zero, eff_mode, c0, c1, sym_done;
    logic [3:0]          sym;
    logic signed [2:0]   lvl_i, lvl_q;

    assign slot      = !out_valid_q || bus.out_ready;
    assign in_fire   = bus.in_valid && in_ready;
    assign tail_last = flush_step && (tail_q == c_TAIL_LAST);
    assign enc_en    = in_fire || flush_step;
    // The first bit of a frame must already use the mode it is about to latch
    assign eff_mode  = (state_q == IDLE) ? bus.mode : mode_q;

    conv_enc_k #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_enc (
        .clk    (clk),
        .reset  (reset),
        .en_i   (enc_en),
        .zero_i (enc_zero),
        .bit_i  (bus.in_bit),
        .c0_o   (c0),
        .c1_o   (c1)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_fire) state_d = bus.in_last ? FLUSH : RUN;
            RUN:     if (in_fire && bus.in_last) state_d = FLUSH;
            FLUSH:   if (tail_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        flush_step = 1'b0;
        enc_zero   = 1'b0;
        case (state_q)
            FLUSH: begin
                flush_step = slot;
                enc_zero   = 1'b1;
            end
            default: in_ready = slot && reset;
        endcase
    end

    // Symbol assembly; a trailing 16-QAM half symbol is zero-padded on the last tail bit
    always_comb begin
        mode_d   = mode_q;
        half_d   = half_q;
        acc_d    = acc_q;
        tail_d   = tail_q;
        sym_done = 1'b0;
        sym      = '0;
        if (in_fire && (state_q == IDLE)) mode_d = bus.mode;
        if (flush_step) tail_d = tail_last ? '0 : tail_q + 1'b1;
        if (enc_en) begin
            if (eff_mode == MODE_QPSK) begin
                sym      = {2'b00, c0, c1};
                sym_done = 1'b1;
            end else if (half_q) begin
                sym      = {acc_q, c0, c1};
                sym_done = 1'b1;
                half_d   = 1'b0;
            end else if (tail_last) begin
                sym      = {c0, c1, 2'b00};
                sym_done = 1'b1;
            end else begin
                acc_d  = {c0, c1};
                half_d = 1'b1;
            end
        end
    end

    always_comb begin
        if (eff_mode == MODE_QPSK) begin
            lvl_i = sym[1] ? 3'sd1 : -3'sd1;
            lvl_q = sym[0] ? 3'sd1 : -3'sd1;
        end else begin
            lvl_i = gray2lvl(sym[3:2]);
            lvl_q = gray2lvl(sym[1:0]);
        end
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        i_smp_d     = i_smp_q;
        q_smp_d     = q_smp_q;
        if (sym_done) begin
            out_valid_d = 1'b1;
            out_last_d  = tail_last;
            i_smp_d     = W'(lvl_i) * c_AMP;
            q_smp_d     = W'(lvl_q) * c_AMP;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q      <= MODE_QPSK;
            half_q      <= 1'b0;
            acc_q       <= '0;
            tail_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            i_smp_q     <= '0;
            q_smp_q     <= '0;
        end else begin
            mode_q      <= mode_d;
            half_q      <= half_d;
            acc_q       <= acc_d;
            tail_q      <= tail_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            i_smp_q     <= i_smp_d;
            q_smp_q     <= q_smp_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_i     = i_smp_q;
    assign bus.out_q     = q_smp_q;

endmodule

`default_nettype wire

// File: tb/tb_qam_tx_frontend.sv
// ============================================================================
// tb_qam_tx_frontend : scoreboard bench with a convolution-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_qam_tx_frontend;

    localparam int           K   = 3;
    localparam int           W   = 9;
    localparam int           AMP = 32;
    localparam logic [K-1:0] G0  = 3'b111;
    localparam logic [K-1:0] G1  = 3'b101;

    typedef struct {
        int i;
        int q;
        bit last;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    exp_t exp_q[$];
    exp_t e_m;
    bit   frame_bits[$];
    int   total    = 0;
    int   bad      = 0;
    int   rdy_pct  = 100;
    bit   rdy_hold = 1'b0;
    int   gap_max  = 0;

    qam_tx_frontend_if #(.W(W)) bus ();

    qam_tx_frontend #(
        .K   (K),
        .G0  (G0),
        .G1  (G1),
        .W   (W),
        .AMP (AMP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        bus.out_ready = !rdy_hold && ($urandom_range(99, 0) < rdy_pct);
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic push_exp(input int i, input int q, input bit last);
        exp_t e;
        e.i = i;
        e.q = q;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Expected symbols from the code's defining convolution, tail and Gray table
    task automatic model_push(input bit m);
        bit           u[$];
        bit           cb[$];
        bit [K-1:0]   g0v = G0;
        bit [K-1:0]   g1v = G1;
        int           gl[4] = '{-3, -1, 3, 1};
        int           bps = m ? 4 : 2;
        int           nsym;
        u = frame_bits;
        repeat (K - 1) u.push_back(1'b0);
        for (int t = 0; t < u.size(); t++) begin
            bit a0 = 1'b0;
            bit a1 = 1'b0;
            for (int j = 0; j < K; j++) begin
                if (t - j >= 0) begin
                    a0 ^= g0v[K-1-j] & u[t-j];
                    a1 ^= g1v[K-1-j] & u[t-j];
                end
            end
            cb.push_back(a0);
            cb.push_back(a1);
        end
        while (cb.size() % bps != 0) cb.push_back(1'b0);
        nsym = cb.size() / bps;
        for (int s = 0; s < nsym; s++) begin
            int b = s * bps;
            if (m) push_exp(gl[{cb[b], cb[b+1]}] * AMP, gl[{cb[b+2], cb[b+3]}] * AMP, s == nsym - 1);
            else   push_exp(cb[b] ? AMP : -AMP, cb[b+1] ? AMP : -AMP, s == nsym - 1);
        end
    endtask

    task automatic wait_accept();
        int guard = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            guard++;
            if (guard > 1000) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 1000 cycles");
                finish_run();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit m, input bit toggle);
        bus.mode = m;
        for (int n = 0; n < frame_bits.size(); n++) begin
            int g = $urandom_range(gap_max, 0);
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b1;
            bus.in_bit   = frame_bits[n];
            bus.in_last  = (n == frame_bits.size() - 1);
            wait_accept();
            if (n == 0 && toggle) bus.mode = ~m;
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
    endtask

    task automatic rand_bits(input int n);
        frame_bits.delete();
        repeat (n) frame_bits.push_back(1'($urandom_range(1, 0)));
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 || bus.out_valid) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 2000) begin
                total++;
                bad++;
                $display("FAIL drain_timeout: %0d symbols outstanding, required 0", exp_q.size());
                break;
            end
        end
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // Monitor: scoreboard pops on every transfer, plus hold-under-stall checks
    bit                  prev_stall = 1'b0;
    logic signed [W-1:0] p_i, p_q;
    logic                p_last;

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", int'(bus.out_valid), 1);
                chk("hold_i", int'($signed(bus.out_i)), int'(p_i));
                chk("hold_q", int'($signed(bus.out_q)), int'(p_q));
                chk("hold_last", int'(bus.out_last), int'(p_last));
            end
            if (bus.out_valid && !bus.out_ready) chk("stall_in_ready", int'(bus.in_ready), 0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_symbol: got i=%0d q=%0d last=%0d, required none",
                             $signed(bus.out_i), $signed(bus.out_q), bus.out_last);
                end else begin
                    e_m = exp_q.pop_front();
                    chk("sym_i", int'($signed(bus.out_i)), e_m.i);
                    chk("sym_q", int'($signed(bus.out_q)), e_m.q);
                    chk("sym_last", int'(bus.out_last), int'(e_m.last));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            p_i        = bus.out_i;
            p_q        = bus.out_q;
            p_last     = bus.out_last;
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.in_last   = 1'b0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b1;
        reset         = 1'b0;

        repeat (3) begin
            @(negedge clk);
            chk("rst_out_valid", int'(bus.out_valid), 0);
            chk("rst_in_ready", int'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("idle_out_valid", int'(bus.out_valid), 0);
        chk("idle_out_i", int'($signed(bus.out_i)), 0);
        chk("idle_out_q", int'($signed(bus.out_q)), 0);
        chk("idle_out_last", int'(bus.out_last), 0);
        chk("idle_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        // QPSK single-bit frame
        frame_bits = '{1'b1};
        push_exp(32, 32, 1'b0);
        push_exp(32, -32, 1'b0);
        push_exp(32, 32, 1'b1);
        send_frame(1'b0, 1'b0);
        wait_drain();
        @(negedge clk);
        chk("back_to_idle_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        // 16-QAM two-bit frame
        frame_bits = '{1'b1, 1'b0};
        push_exp(32, 96, 1'b0);
        push_exp(32, -96, 1'b1);
        send_frame(1'b1, 1'b0);
        wait_drain();

        // Backpressure over a 64-bit QPSK stream
        rand_bits(64);
        model_push(1'b0);
        fork
            send_frame(1'b0, 1'b0);
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                rdy_hold = 1'b1;
                repeat (5) begin
                    @(posedge clk);
                    @(negedge clk);
                    chk("bp_out_valid", int'(bus.out_valid), 1);
                    chk("bp_in_ready", int'(bus.in_ready), 0);
                end
                rdy_hold = 1'b0;
                rdy_pct  = 70;
            end
        join
        wait_drain();

        // Mode toggled after the first bit: frame keeps the latched mode
        gap_max = 2;
        rdy_pct = 60;
        for (int m = 1; m >= 0; m--) begin
            rand_bits(9);
            model_push(1'(m));
            send_frame(1'(m), 1'b1);
            wait_drain();
            rand_bits(5);
            model_push(1'(1 - m));
            send_frame(1'(1 - m), 1'b0);
            wait_drain();
        end

        // Reset during the stalled tail discards the frame
        gap_max = 0;
        rdy_pct = 100;
        @(negedge clk);
        rdy_hold = 1'b1;
        @(posedge clk);
        #1;
        frame_bits = '{1'b1};
        send_frame(1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_flush_out_valid", int'(bus.out_valid), 0);
        chk("rst_flush_out_last", int'(bus.out_last), 0);
        rdy_hold = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_quiet", int'(bus.out_valid), 0);
        end
        @(posedge clk);
        #1;
        frame_bits = '{1'b1};
        push_exp(32, 32, 1'b0);
        push_exp(32, -32, 1'b0);
        push_exp(32, 32, 1'b1);
        send_frame(1'b0, 1'b0);
        wait_drain();

        // Random frames, random modes, gaps and backpressure
        gap_max = 3;
        rdy_pct = 65;
        for (int f = 0; f < 8; f++) begin
            bit m  = 1'($urandom_range(1, 0));
            bit tg = 1'($urandom_range(1, 0));
            rand_bits(int'($urandom_range(24, 1)));
            model_push(m);
            send_frame(m, tg);
        end
        wait_drain();

        finish_run();
    end

endmodule

`default_nettype wire

// File: doc/qam_tx_frontend.md
Name: qam_tx_frontend

Overview:
- Parametrised successor of the fixed-rate transmit chain: rate-1/2 convolutional encoder, selectable QPSK/16-QAM Gray mapper and frame tail flush, in one clock domain with ready/valid handshakes on both sides.
- Accepts a serial source bit stream, from the M-sequence generator or payload logic.
- Emits signed I/Q symbol pairs toward the channel model / DAC path.
- The output width defaults to the existing 9-bit channel sample width.

Parameters:
- K, 3, constraint length (encoder register depth K-1), range 3..9.
- G0, 3'b111 (octal 7), first generator polynomial; MSB taps the current input bit.
- G1, 3'b101 (octal 5), second generator polynomial.
- W, 9, signed output width of each I/Q sample.
- AMP, 32, unit amplitude; requires 3*AMP < 2^(W-1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- mode  in  1  0 = QPSK (2 coded bits/symbol), 1 = 16-QAM (4 coded bits/symbol); sampled only at frame start.
- in_valid  in  1  source bit valid.
- in_ready  out  1  block can accept a bit this cycle.
- in_bit  in  1  source data bit.
- in_last  in  1  accompanies the final source bit of a frame.
- out_valid  out  1  symbol valid.
- out_ready  in  1  downstream accepts the symbol.
- out_i  out  W  signed in-phase sample.
- out_q  out  W  signed quadrature sample.
- out_last  out  1  final symbol of the frame.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (reset==0 at a clk edge).
- Reset values: out_valid=0, out_i=0, out_q=0, out_last=0, in_ready=0 during reset. Encoder register, accumulator and state are all cleared; state = IDLE.
- Reset mid-frame discards the frame entirely. No partial symbol or out_last is emitted afterwards.
- Handshake: a transfer occurs when valid && ready are both high at a clk edge. out_* are held stable while out_valid && !out_ready.
- in_ready = (state != FLUSH) && (!out_valid || out_ready) && reset.
- Encoder: on each accepted bit u, c0 = parity(G0 & {u, sr}) and c1 = parity(G1 & {u, sr}), then sr <= {u, sr[K-2:1]}. c0 is ordered before c1.
- Accumulator:
  - Coded bits are appended MSB-first.
  - A symbol completes when 2 bits (QPSK) or 4 bits (16-QAM) are present.
  - On completion the output register loads at the same edge, so out_valid rises the cycle after the accepting edge (latency 1).
  - A 16-QAM half symbol stays pending without needing an output slot.
- QPSK mapping: bits b1 b0 give I from b1, Q from b0; bit 0 -> -AMP, bit 1 -> +AMP.
- 16-QAM mapping: bits b3..b0 give I from b3b2, Q from b1b0. Gray levels: 00 -> -3*AMP, 01 -> -AMP, 11 -> +AMP, 10 -> +3*AMP.
- FSM states:
  - IDLE: sr==0. The first accepted bit latches mode into mode_q and goes to RUN. If that bit has in_last, go straight to FLUSH.
  - RUN: accepted bit with in_last -> FLUSH, else stay in RUN.
  - FLUSH: injects K-1 zero bits, one per cycle when (!out_valid || out_ready). If the coded-bit count is not a symbol multiple after the final tail bit, zero-pad to complete the symbol. The symbol holding the last tail/pad bit carries out_last=1. The FLUSH -> IDLE transition happens on the edge that loads that symbol.
- mode changes outside IDLE are ignored. Frames are never split across modes.
- Simultaneous output drain and new symbol load in the same cycle is legal and gives zero bubbles. Full throughput is 1 bit/cycle in QPSK.
- out_i/out_q keep their last values when out_valid=0.

Decomposition:
- Shared package qam_tx_pkg:
  - mode encodings MODE_QPSK / MODE_16QAM;
  - FSM state typedef {IDLE, RUN, FLUSH};
  - Gray-level function gray2lvl(2-bit) returning -3/-1/+1/+3.
- One sub-module, conv_enc_k: parametrised K/G0/G1, with an enable and a zero-force input for the tail.
- Mapper and FSM live in the top.

Test Plan (K=3, G0=7, G1=5, AMP=32, W=9):
- Reset then idle: hold reset=0 for 3 cycles, release -> out_valid=0, out_i=out_q=0, in_ready=1 the first cycle after release.
- QPSK single-bit frame: in_bit=1 with in_last -> symbols (+32,+32), (+32,-32), (+32,+32); out_last only on the third symbol; FSM returns to IDLE.
- 16-QAM frame: bits 1,0 with last on 0 -> symbols (+32,+96) then (+32,-96) with out_last=1.
- Backpressure: QPSK stream with out_ready=0 for 5 cycles -> in_ready=0 and out_* stable throughout. After release there is no loss or duplication, confirmed against a reference encoder model over 64 random bits.
- Mode change mid-frame: toggle mode during RUN -> symbols keep the latched mode; the new mode takes effect only from the next frame.
- Reset mid-FLUSH: assert reset during the tail -> out_valid=0 the next cycle and no out_last. The following frame encodes from a zero state, identical to the single-bit case above.
